// File: rtl/sub_serial.sv
// ============================================================================
//  Module   : sub_serial
//  Brief    : Bit-serial signed subtractor (A - B), one bit per clock, with
//             start/busy/done handshake plus borrow and zero flags.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sub_serial #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] port_A,
    input  logic [DATA_WIDTH-1:0] port_B,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH:0]   result,
    output logic                  borrow_flag,
    output logic                  zero_flag
);

    localparam int            CNT_W       = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST_BIT   = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] C_BORROW_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH:0]   a_sr_q, a_sr_d;
    logic [DATA_WIDTH:0]   b_sr_q, b_sr_d;
    logic [DATA_WIDTH:0]   work_q, work_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  carry_q, carry_d;
    logic                  borrow_work_q, borrow_work_d;
    logic [DATA_WIDTH:0]   result_q, result_d;
    logic                  borrow_q, borrow_d;
    logic                  zero_q, zero_d;

    logic                  w_a;
    logic                  w_nb;
    logic                  w_diff;
    logic                  w_cout;
    logic [DATA_WIDTH:0]   w_work_shifted;

    // Full-adder slice for A + ~B + 1, fed from the operand LSBs
    assign w_a            = a_sr_q[0];
    assign w_nb           = ~b_sr_q[0];
    assign w_diff         = w_a ^ w_nb ^ carry_q;
    assign w_cout         = (w_a & w_nb) | (w_a & carry_q) | (w_nb & carry_q);
    assign w_work_shifted = {w_diff, work_q[DATA_WIDTH:1]};

    always_comb begin
        state_d       = state_q;
        a_sr_d        = a_sr_q;
        b_sr_d        = b_sr_q;
        work_d        = work_q;
        cnt_d         = cnt_q;
        carry_d       = carry_q;
        borrow_work_d = borrow_work_q;
        result_d      = result_q;
        borrow_d      = borrow_q;
        zero_d        = zero_q;

        case (state_q)
            IDLE, DONE: begin
                // DONE doubles as an accepting state for back-to-back operation
                if (start) begin
                    a_sr_d  = {port_A[DATA_WIDTH-1], port_A};
                    b_sr_d  = {port_B[DATA_WIDTH-1], port_B};
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                carry_d = w_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                work_d  = w_work_shifted;
                if (cnt_q == C_BORROW_BIT) begin
                    borrow_work_d = ~w_cout;
                end
                if (cnt_q == C_LAST_BIT) begin
                    state_d  = DONE;
                    result_d = w_work_shifted;
                    borrow_d = borrow_work_q;
                    zero_d   = (w_work_shifted == '0);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            a_sr_q        <= '0;
            b_sr_q        <= '0;
            work_q        <= '0;
            cnt_q         <= '0;
            carry_q       <= 1'b0;
            borrow_work_q <= 1'b0;
            result_q      <= '0;
            borrow_q      <= 1'b0;
            zero_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_sr_q        <= a_sr_d;
            b_sr_q        <= b_sr_d;
            work_q        <= work_d;
            cnt_q         <= cnt_d;
            carry_q       <= carry_d;
            borrow_work_q <= borrow_work_d;
            result_q      <= result_d;
            borrow_q      <= borrow_d;
            zero_q        <= zero_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign result      = result_q;
    assign borrow_flag = borrow_q;
    assign zero_flag   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_sub_serial.sv
// ============================================================================
//  Module   : tb_sub_serial
//  Brief    : Self-checking bench for sub_serial (vector table, handshake
//             corner sequences, randomized operands against an arithmetic model).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sub_serial;

    localparam int DATA_WIDTH = 8;
    localparam int LATENCY    = DATA_WIDTH + 2;
    localparam int MAX_WAIT   = 40;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [DATA_WIDTH-1:0] port_A;
    logic [DATA_WIDTH-1:0] port_B;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH:0]   result;
    logic                  borrow_flag;
    logic                  zero_flag;

    int n_checks;
    int n_fail;

    sub_serial #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .port_A      (port_A),
        .port_B      (port_B),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .borrow_flag (borrow_flag),
        .zero_flag   (zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] exp_res;
        logic       exp_borrow;
        logic       exp_zero;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact signed difference, unsigned compare for borrow
    function automatic logic [8:0] ref_diff(input logic [7:0] a, input logic [7:0] b);
        int d;
        d = int'($signed(a)) - int'($signed(b));
        return d[8:0];
    endfunction

    // Drives start for one cycle; returns at the falling edge of the first RUN cycle
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start  = 1'b1;
        port_A = a;
        port_B = b;
        @(negedge clk);
        start  = 1'b0;
        port_A = 8'($urandom);
        port_B = 8'($urandom);
    endtask

    // Counts cycles since acceptance (current cycle = 1) until done, bounded
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    vec_t vecs[8];

    initial begin
        int         n;
        logic [8:0] prev_res;
        logic [7:0] ra, rb;
        logic       saw_done;

        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        port_A   = '0;
        port_B   = '0;

        vecs[0] = '{8'h05, 8'h03, 9'h002, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 9'h1FE, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h7F, 9'h101, 1'b0, 1'b0};
        vecs[3] = '{8'h7F, 8'h80, 9'h0FF, 1'b1, 1'b0};
        vecs[4] = '{8'h55, 8'h55, 9'h000, 1'b0, 1'b1};
        vecs[5] = '{8'hFF, 8'h01, 9'h1FE, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 8'hFF, 9'h002, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 9'h000, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_busy",   32'(busy),        32'd0);
        check("reset_done",   32'(done),        32'd0);
        check("reset_result", 32'(result),      32'd0);
        check("reset_borrow", 32'(borrow_flag), 32'd0);
        check("reset_zero",   32'(zero_flag),   32'd0);
        rst = 1'b0;

        // Table-driven vectors
        prev_res = 9'h000;
        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].a, vecs[i].b);
            check("busy_first_run", 32'(busy), 32'd1);
            repeat (4) @(negedge clk);
            check("result_held_in_run", 32'(result), 32'(prev_res));
            n = 5;
            while (!done && n < MAX_WAIT) begin
                @(negedge clk);
                n++;
            end
            check("vec_latency", 32'(n),           32'(LATENCY));
            check("vec_result",  32'(result),      32'(vecs[i].exp_res));
            check("vec_borrow",  32'(borrow_flag), 32'(vecs[i].exp_borrow));
            check("vec_zero",    32'(zero_flag),   32'(vecs[i].exp_zero));
            check("vec_busy_in_done", 32'(busy),   32'd0);
            prev_res = vecs[i].exp_res;
            @(negedge clk);
            check("done_single_pulse", 32'(done), 32'd0);
        end

        // Start during RUN (3rd RUN cycle) must be ignored
        launch(8'd20, 8'd7);
        repeat (2) @(negedge clk);
        start  = 1'b1;
        port_A = 8'd100;
        port_B = 8'd1;
        @(negedge clk);
        start  = 1'b0;
        n = 4;
        while (!done && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        check("ignored_start_latency", 32'(n),      32'(LATENCY));
        check("ignored_start_result",  32'(result), 32'h00D);
        @(negedge clk);
        check("ignored_start_no_requeue", 32'(busy), 32'd0);

        // Back-to-back: start accepted in the DONE cycle
        launch(8'd9, 8'd4);
        wait_done(n);
        check("b2b_first_latency", 32'(n),      32'(LATENCY));
        check("b2b_first_result",  32'(result), 32'h005);
        start  = 1'b1;
        port_A = 8'd1;
        port_B = 8'd2;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_dropped", 32'(done), 32'd0);
        check("b2b_busy",         32'(busy), 32'd1);
        wait_done(n);
        check("b2b_second_latency", 32'(n),           32'(LATENCY));
        check("b2b_second_result",  32'(result),      32'h1FF);
        check("b2b_second_borrow",  32'(borrow_flag), 32'd1);

        // Reset in the 5th RUN cycle aborts the operation
        launch(8'd50, 8'd60);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",   32'(busy),        32'd0);
        check("abort_done",   32'(done),        32'd0);
        check("abort_result", 32'(result),      32'd0);
        check("abort_borrow", 32'(borrow_flag), 32'd0);
        check("abort_zero",   32'(zero_flag),   32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        launch(8'd50, 8'd60);
        wait_done(n);
        check("after_abort_latency", 32'(n),           32'(LATENCY));
        check("after_abort_result",  32'(result),      32'h1F6);
        check("after_abort_borrow",  32'(borrow_flag), 32'd1);

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i == 0) rb = ra;
            launch(ra, rb);
            wait_done(n);
            check("rand_latency", 32'(n),           32'(LATENCY));
            check("rand_result",  32'(result),      32'(ref_diff(ra, rb)));
            check("rand_borrow",  32'(borrow_flag), 32'(ra < rb));
            check("rand_zero",    32'(zero_flag),   32'(ra == rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sub_serial.md
# sub_serial

Bit-serial signed subtractor for the ALU datapath: the counterpart of the combinational adder. It computes port_A − port_B one bit per clock. The difference is exact and sign-extended to DATA_WIDTH+1 bits, with borrow and zero flags. It uses a start/busy/done handshake, so the ALU controller can trade area for latency on the subtract path.

## Interface
- DATA_WIDTH, 8: operand width in bits, two's complement; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- port_A  input  DATA_WIDTH  signed minuend; sampled with an accepted start.
- port_B  input  DATA_WIDTH  signed subtrahend; sampled with an accepted start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when result and flags update.
- result  output  DATA_WIDTH+1  signed port_A − port_B, held until the next completion.
- borrow_flag  output  1  unsigned borrow out of bit DATA_WIDTH−1, i.e. unsigned port_A < unsigned port_B.
- zero_flag  output  1  set when the completed result is 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 is accepted.
  - Latch sign-extended copies of port_A and port_B (DATA_WIDTH+1 bits each).
  - Set carry register to 1. The operation is A + ~B + 1.
  - Clear bit counter; go to RUN.
- RUN: each edge processes the LSBs a, b of the operand shift registers.
  - Difference bit d = a ^ ~b ^ c, shifted into the working result register from the MSB side.
  - Next carry c' = (a & ~b) | (a & c) | (~b & c).
  - Both operand registers shift right by 1; counter increments.
  - On the edge processing bit index DATA_WIDTH−1, capture borrow = ~c'.
  - After the edge processing bit index DATA_WIDTH (the sign bit), go to DONE.
- DONE (lasts one cycle): done=1; result, borrow_flag and zero_flag become the new values.
  - If start=1 in this cycle, it is accepted exactly as in IDLE and the state goes to RUN.
  - Otherwise go to IDLE.
- start while in RUN is ignored, not queued. Operand inputs are don't-care outside the accepting cycle.
- Width: the DATA_WIDTH+1 result never overflows. The full range is −(2^DATA_WIDTH−1) to +(2^DATA_WIDTH−1).
- Outputs hold their last completed values in IDLE and during RUN.
  - Output registers are written only on the transition into DONE.
  - The working register is internal.

## Timing
- Reset values: state IDLE, busy=0, done=0, result=0, borrow_flag=0, zero_flag=0, counter=0.
  - Flags are meaningless until the first done.
- rst is synchronous and has priority over everything.
  - Asserting it mid-RUN aborts the operation.
  - No done is issued; outputs return to reset values on that edge.
- Latency: start accepted at edge k.
  - RUN edges are k+1 … k+DATA_WIDTH+1.
  - done is high during the cycle following edge k+DATA_WIDTH+1. This is DATA_WIDTH+2 cycles after acceptance (10 for DATA_WIDTH=8).
- busy=1 from the cycle after acceptance through the last RUN cycle. It is 0 in DONE and IDLE.
- Throughput: back-to-back operations using start in the DONE cycle give one result every DATA_WIDTH+2 cycles.
- done never stays high two consecutive cycles.

## Test plan
- Basic subtract: A=5, B=3, DATA_WIDTH=8 → done at cycle 10; result=9'h002, borrow=0, zero=0.
- Negative result: A=3, B=5 → result=9'h1FE (−2), borrow=1, zero=0.
- Range extremes:
  - A=−128, B=127 → result=9'h101 (−255), borrow=0.
  - A=127, B=−128 → result=9'h0FF (+255), borrow=1.
- Zero result: A=8'h55, B=8'h55 → result=0, zero=1, borrow=0. The previous result stays stable on the outputs until this done.
- Handshake:
  - Pulse start again in the 3rd RUN cycle with different operands → ignored; original result delivered.
  - Assert start in the DONE cycle with A=1, B=2 → accepted; second done exactly 10 cycles later with result=9'h1FF.
- Reset mid-operation: assert rst in the 5th RUN cycle → next edge gives busy=0, done=0, result=0, flags 0; no done follows. A fresh start then completes normally.
